// File: rtl/sargantana_icache_inval_seq.sv
// +--------------------------------------------------------------------------+
// | Module   : sargantana_icache_inval_seq                                   |
// | Purpose  : Icache invalidation initiator. Serialises fence.i full-cache  |
// |            flushes and external per-line invalidations onto a single     |
// |            one-line-per-cycle inval strobe. ICACHE_INVAL_FIFO_EN selects |
// |            a circular FIFO for external requests instead of one register.|
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module sargantana_icache_inval_seq #(
  parameter int ICACHE_N_WAY     = 4,
  parameter int ICACHE_IDX_WIDTH = 6,
  parameter int INVAL_FIFO_DEPTH = 4
) (
  input  logic                            clk_i,
  input  logic                            rstn_i,
  input  logic                            flush_req_i,
  output logic                            flush_ack_o,
  input  logic                            ext_inval_valid_i,
  output logic                            ext_inval_ready_o,
  input  logic [ICACHE_IDX_WIDTH-1:0]     ext_inval_idx_i,
  input  logic [$clog2(ICACHE_N_WAY)-1:0] ext_inval_way_i,
  input  logic                            cache_busy_i,
  output logic                            inval_o,
  output logic [ICACHE_IDX_WIDTH-1:0]     inval_idx_o,
  output logic [ICACHE_N_WAY-1:0]         inval_way_oh_o,
  output logic                            flush_ena_o
);

  localparam int c_way_w = $clog2(ICACHE_N_WAY);
  localparam logic [ICACHE_IDX_WIDTH-1:0] c_max_idx = {ICACHE_IDX_WIDTH{1'b1}};

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_flush = 2'd1;
  localparam logic [1:0] c_done  = 2'd2;

  logic [1:0]                  r_state;
  logic [ICACHE_IDX_WIDTH-1:0] r_cnt;

  logic                        w_buf_empty;
  logic                        w_buf_full;
  logic [ICACHE_IDX_WIDTH-1:0] w_head_idx;
  logic [c_way_w-1:0]          w_head_way;
  logic                        w_push;
  logic                        w_pop;
  logic                        w_clear;
  logic                        w_idle;

  assign w_idle  = (r_state == c_idle);
  // A pending flush request takes the cycle away from buffered ext invals and
  // discards them, since the flush invalidates those lines anyway.
  assign w_clear = w_idle & flush_req_i;
  assign w_pop   = w_idle & ~flush_req_i & ~w_buf_empty & ~cache_busy_i;
  assign w_push  = ext_inval_valid_i & ext_inval_ready_o;

  assign ext_inval_ready_o = w_idle & ~w_buf_full & ~flush_req_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= c_idle;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (flush_req_i) begin
            r_state <= c_flush;
            r_cnt   <= '0;
          end
        end
        c_flush: begin
          if (!cache_busy_i) begin
            r_cnt <= r_cnt + ICACHE_IDX_WIDTH'(1);
            if (r_cnt == c_max_idx) begin
              r_state <= c_done;
            end
          end
        end
        c_done:  r_state <= c_idle;
        default: r_state <= c_idle;
      endcase
    end
  end

`ifdef ICACHE_INVAL_FIFO_EN
  localparam int c_ptr_w = $clog2(INVAL_FIFO_DEPTH);

  logic [c_ptr_w:0]            r_wr_ptr;
  logic [c_ptr_w:0]            r_rd_ptr;
  logic [ICACHE_IDX_WIDTH-1:0] r_mem_idx [INVAL_FIFO_DEPTH];
  logic [c_way_w-1:0]          r_mem_way [INVAL_FIFO_DEPTH];

  // Pointers carry one extra wrap bit to tell full from empty.
  assign w_buf_empty = (r_wr_ptr == r_rd_ptr);
  assign w_buf_full  = (r_wr_ptr[c_ptr_w] != r_rd_ptr[c_ptr_w]) &&
                       (r_wr_ptr[c_ptr_w-1:0] == r_rd_ptr[c_ptr_w-1:0]);
  assign w_head_idx  = r_mem_idx[r_rd_ptr[c_ptr_w-1:0]];
  assign w_head_way  = r_mem_way[r_rd_ptr[c_ptr_w-1:0]];

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (w_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (c_ptr_w+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (c_ptr_w+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_idx[r_wr_ptr[c_ptr_w-1:0]] <= ext_inval_idx_i;
      r_mem_way[r_wr_ptr[c_ptr_w-1:0]] <= ext_inval_way_i;
    end
  end
`else
  logic                        r_hold_vld;
  logic [ICACHE_IDX_WIDTH-1:0] r_hold_idx;
  logic [c_way_w-1:0]          r_hold_way;
  logic [31:0]                 w_unused_depth;

  assign w_unused_depth = INVAL_FIFO_DEPTH;
  assign w_buf_empty    = ~r_hold_vld;
  assign w_buf_full     = r_hold_vld;
  assign w_head_idx     = r_hold_idx;
  assign w_head_way     = r_hold_way;

  // Ready is low while the entry is held, so push and pop never coincide.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_hold_vld <= 1'b0;
      r_hold_idx <= '0;
      r_hold_way <= '0;
    end else if (w_clear || w_pop) begin
      r_hold_vld <= 1'b0;
    end else if (w_push) begin
      r_hold_vld <= 1'b1;
      r_hold_idx <= ext_inval_idx_i;
      r_hold_way <= ext_inval_way_i;
    end
  end
`endif

  always_comb begin
    inval_o        = 1'b0;
    inval_idx_o    = '0;
    inval_way_oh_o = '0;
    flush_ack_o    = 1'b0;
    flush_ena_o    = 1'b0;
    case (r_state)
      c_flush: begin
        flush_ena_o    = 1'b1;
        inval_o        = ~cache_busy_i;
        inval_idx_o    = r_cnt;
        inval_way_oh_o = '1;
      end
      c_done: begin
        flush_ena_o = 1'b1;
        flush_ack_o = 1'b1;
      end
      default: begin
        if (!w_buf_empty) begin
          inval_o        = w_pop;
          inval_idx_o    = w_head_idx;
          inval_way_oh_o = {{(ICACHE_N_WAY-1){1'b0}}, 1'b1} << w_head_way;
        end
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_sargantana_icache_inval_seq.sv
// Directed self-checking bench for sargantana_icache_inval_seq (default parameters).
`default_nettype none

module tb_sargantana_icache_inval_seq;

  logic       clk_i = 1'b0;
  logic       rstn_i;
  logic       flush_req_i;
  logic       flush_ack_o;
  logic       ext_inval_valid_i;
  logic       ext_inval_ready_o;
  logic [5:0] ext_inval_idx_i;
  logic [1:0] ext_inval_way_i;
  logic       cache_busy_i;
  logic       inval_o;
  logic [5:0] inval_idx_o;
  logic [3:0] inval_way_oh_o;
  logic       flush_ena_o;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef ICACHE_INVAL_FIFO_EN
  localparam int c_nbuf = 4;
`else
  localparam int c_nbuf = 1;
`endif

  sargantana_icache_inval_seq dut (
    .clk_i             (clk_i),
    .rstn_i            (rstn_i),
    .flush_req_i       (flush_req_i),
    .flush_ack_o       (flush_ack_o),
    .ext_inval_valid_i (ext_inval_valid_i),
    .ext_inval_ready_o (ext_inval_ready_o),
    .ext_inval_idx_i   (ext_inval_idx_i),
    .ext_inval_way_i   (ext_inval_way_i),
    .cache_busy_i      (cache_busy_i),
    .inval_o           (inval_o),
    .inval_idx_o       (inval_idx_o),
    .inval_way_oh_o    (inval_way_oh_o),
    .flush_ena_o       (flush_ena_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Called at negedge; drives a flush from the request cycle to the cycle after ack.
  // A stall of stall_len busy cycles is inserted when index stall_at is due;
  // abort_at >= 0 returns right after that index has been observed.
  task automatic run_flush(input int stall_at, input int stall_len, input int abort_at);
    int idx;
    int st;
    flush_req_i = 1'b1;
    cache_busy_i = 1'b0;
    #1;
    check("req_ready", 32'(ext_inval_ready_o), 0);
    check("req_inval", 32'(inval_o), 0);
    check("req_ena", 32'(flush_ena_o), 0);
    @(negedge clk_i);
    idx = 0;
    st  = 0;
    while (idx < 64) begin
      cache_busy_i = (idx == stall_at) && (st < stall_len);
      #1;
      check("flush_ena", 32'(flush_ena_o), 1);
      check("flush_ack_early", 32'(flush_ack_o), 0);
      if (cache_busy_i) begin
        check("stall_inval", 32'(inval_o), 0);
        st++;
      end else begin
        check("flush_inval", 32'(inval_o), 1);
        check("flush_idx", 32'(inval_idx_o), 32'(idx));
        check("flush_way", 32'(inval_way_oh_o), 32'hF);
        if (idx == abort_at) return;
        idx++;
      end
      @(negedge clk_i);
    end
    cache_busy_i = 1'b0;
    #1;
    check("ack", 32'(flush_ack_o), 1);
    check("ack_inval", 32'(inval_o), 0);
    check("ack_ena", 32'(flush_ena_o), 1);
    check("ack_ready", 32'(ext_inval_ready_o), 0);
    flush_req_i = 1'b0;
    @(negedge clk_i);
    #1;
    check("post_ack", 32'(flush_ack_o), 0);
    check("post_ena", 32'(flush_ena_o), 0);
    check("post_inval", 32'(inval_o), 0);
    check("post_ready", 32'(ext_inval_ready_o), 1);
    @(negedge clk_i);
  endtask

  initial begin
    rstn_i            = 1'b0;
    flush_req_i       = 1'b0;
    ext_inval_valid_i = 1'b0;
    ext_inval_idx_i   = '0;
    ext_inval_way_i   = '0;
    cache_busy_i      = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    #1;
    check("rst_inval", 32'(inval_o), 0);
    check("rst_idx", 32'(inval_idx_o), 0);
    check("rst_way", 32'(inval_way_oh_o), 0);
    check("rst_ack", 32'(flush_ack_o), 0);
    check("rst_ena", 32'(flush_ena_o), 0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    #1;
    check("rst_ready", 32'(ext_inval_ready_o), 1);
    @(negedge clk_i);

    // Plain flush, then flush with a 3-cycle stall at index 10.
    run_flush(-1, 0, -1);
    run_flush(10, 3, -1);

    // Single ext inval, idle cache.
    ext_inval_valid_i = 1'b1;
    ext_inval_idx_i   = 6'h2A;
    ext_inval_way_i   = 2'd2;
    #1;
    check("ext_ready", 32'(ext_inval_ready_o), 1);
    check("ext_no_bypass", 32'(inval_o), 0);
    @(negedge clk_i);
    ext_inval_valid_i = 1'b0;
    #1;
    check("ext_inval", 32'(inval_o), 1);
    check("ext_idx", 32'(inval_idx_o), 32'h2A);
    check("ext_way", 32'(inval_way_oh_o), 32'h4);
    @(negedge clk_i);
    #1;
    check("ext_done", 32'(inval_o), 0);
    check("ext_ready_back", 32'(ext_inval_ready_o), 1);
    @(negedge clk_i);

    // Fill the buffer while the cache is busy, then drain in order.
    cache_busy_i = 1'b1;
    for (int k = 0; k < c_nbuf; k++) begin
      ext_inval_valid_i = 1'b1;
      ext_inval_idx_i   = 6'(8'h10 + k);
      ext_inval_way_i   = 2'(k);
      #1;
      check("fill_ready", 32'(ext_inval_ready_o), 1);
      check("fill_busy_inval", 32'(inval_o), 0);
      @(negedge clk_i);
    end
    ext_inval_valid_i = 1'b0;
    #1;
    check("full_ready", 32'(ext_inval_ready_o), 0);
    check("full_busy_inval", 32'(inval_o), 0);
    cache_busy_i = 1'b0;
    for (int k = 0; k < c_nbuf; k++) begin
      #1;
      check("drain_inval", 32'(inval_o), 1);
      check("drain_idx", 32'(inval_idx_o), 32'h10 + 32'(k));
      check("drain_way", 32'(inval_way_oh_o), 32'(1) << k);
      @(negedge clk_i);
    end
    #1;
    check("drained_inval", 32'(inval_o), 0);
    check("drained_ready", 32'(ext_inval_ready_o), 1);
    @(negedge clk_i);

    // Buffered ext invals are dropped by a flush.
    cache_busy_i = 1'b1;
    for (int k = 0; k < ((c_nbuf > 1) ? 2 : 1); k++) begin
      ext_inval_valid_i = 1'b1;
      ext_inval_idx_i   = 6'(8'h20 + k);
      ext_inval_way_i   = 2'(k + 1);
      #1;
      check("pre_flush_ready", 32'(ext_inval_ready_o), 1);
      @(negedge clk_i);
    end
    ext_inval_valid_i = 1'b0;
    run_flush(-1, 0, -1);
    #1;
    check("dropped_inval", 32'(inval_o), 0);
    @(negedge clk_i);

    // Reset in the middle of a flush, then a fresh flush from index 0.
    run_flush(-1, 0, 30);
    rstn_i      = 1'b0;
    flush_req_i = 1'b0;
    #1;
    check("abort_inval", 32'(inval_o), 0);
    check("abort_idx", 32'(inval_idx_o), 0);
    check("abort_way", 32'(inval_way_oh_o), 0);
    check("abort_ena", 32'(flush_ena_o), 0);
    check("abort_ack", 32'(flush_ack_o), 0);
    @(negedge clk_i);
    #1;
    check("abort_hold_ack", 32'(flush_ack_o), 0);
    rstn_i = 1'b1;
    @(negedge clk_i);
    run_flush(-1, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
